dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: data bus and address width.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 256: number of RAM words (power of 2).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: number of TX FIFO entries (power of 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_mem_write_M, input, 1 bit: store strobe from the core M stage.
REQ-007 The block SHALL have port i_data_addr_M, input, DATA_WIDTH bits: byte address from the core M stage.
REQ-008 The block SHALL have port i_write_data_M, input, DATA_WIDTH bits: store data.
REQ-009 The block SHALL have port o_read_data_M, output, DATA_WIDTH bits: load data returned to the core.
REQ-010 The block SHALL have port o_tx_data, output, 8 bits: TX FIFO head byte.
REQ-011 The block SHALL have port o_tx_valid, output, 1 bit: TX FIFO is non-empty.
REQ-012 The block SHALL have port i_tx_ready, input, 1 bit: downstream accepts the head byte.

Function
REQ-013 The block SHALL decode addresses as follows: addr[31]=0 selects RAM; addr[31]=1 selects the peripheral space; addr[1:0] SHALL be ignored everywhere.
REQ-014 RAM accesses SHALL use word index addr[log2(MEM_DEPTH)+1:2]; higher address bits below bit 31 SHALL be ignored, so accesses alias.
REQ-015 A RAM store SHALL write the full word at the clock edge when i_mem_write_M=1.
REQ-016 o_read_data_M SHALL be combinational from registered state in the same cycle as the address; a load from a word being stored in the same cycle SHALL return the old contents.
REQ-017 Peripheral offset 0x8000_0000 (TXDATA): a store SHALL push i_write_data_M[7:0]; a load SHALL return 0.
REQ-018 Peripheral offset 0x8000_0004 (STATUS): a load SHALL return {zeros, overflow[5], full[4], empty[3], count[2:0]}; a store of any value SHALL clear overflow.
REQ-019 Peripheral offset 0x8000_0008 (CYCLE): a load SHALL return the 32-bit cycle counter; a store SHALL load the counter with i_write_data_M.
REQ-020 All other peripheral addresses SHALL read 0, and stores to them SHALL have no effect.
REQ-021 The cycle counter SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0; a store in the same cycle SHALL take priority, and incrementing SHALL resume from the stored value on the following cycle.
REQ-022 The TX FIFO SHALL use a circular buffer with read/write pointers and a count of 0..FIFO_DEPTH; o_tx_valid SHALL equal (count != 0) and o_tx_data SHALL equal the entry at the read pointer.
REQ-023 A pop SHALL occur when o_tx_valid && i_tx_ready; a push SHALL occur on a TXDATA store.
REQ-024 When the FIFO is full, a push with no simultaneous pop SHALL be dropped and set overflow (sticky); a push with a simultaneous pop SHALL be accepted and count SHALL remain FIFO_DEPTH.
REQ-025 When the FIFO is empty, a push SHALL be accepted; the byte SHALL become visible on o_tx_data on the next cycle; no pop SHALL occur.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 If an overflow set and a STATUS clear occur in the same cycle, the set SHALL win.

Reset
REQ-028 While rst=0, the following SHALL be cleared: FIFO pointers and count to 0, FIFO storage to 0, overflow to 0, and the cycle counter to 0; therefore o_tx_valid=0 and o_tx_data=0x00.
REQ-029 RAM contents SHALL NOT be reset; loads from unwritten words are undefined.
REQ-030 Reset asserted mid-operation SHALL discard all queued bytes immediately, without waiting for a clock edge.

Verification
REQ-031 Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> 0xDEADBEEF; load 0x0000_0410 with MEM_DEPTH=256 -> 0xDEADBEEF (alias).
REQ-032 Store 0x41, 0x42, 0x43, 0x44 to TXDATA with i_tx_ready=0 -> STATUS=0x14; a fifth store -> STATUS=0x34; store to STATUS -> STATUS=0x14.
REQ-033 With the FIFO full, hold i_tx_ready=1 and store 0x45 in the same cycle -> count stays 4, overflow=0; then drain -> o_tx_data sequence 0x42, 0x43, 0x44, 0x45.
REQ-034 Store 0xFFFF_FFFE to CYCLE -> load of CYCLE 2 cycles later returns 0x0000_0000 (wrap).
REQ-035 Push 2 bytes, then drop rst to 0 between clock edges -> o_tx_valid=0 immediately; after release, STATUS=0x08 and CYCLE counts from 0.
REQ-036 Load 0x8000_0010 -> 0; a store to 0x8000_0010 changes no observable state.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Core data-memory port plus TX byte stream between the core and dmem_responder.
// The core side is the master; the responder is the slave.
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_mem_write_M;
    logic [DATA_WIDTH-1:0] i_data_addr_M;
    logic [DATA_WIDTH-1:0] i_write_data_M;
    logic [DATA_WIDTH-1:0] o_read_data_M;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;

    modport master (
        output i_mem_write_M, i_data_addr_M, i_write_data_M, i_tx_ready,
        input  o_read_data_M, o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_mem_write_M, i_data_addr_M, i_write_data_M, i_tx_ready,
        output o_read_data_M, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM in the low half of the address space and, in the high
// half, a TX byte FIFO (TXDATA/STATUS registers) and a free-running cycle counter.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = DATA_WIDTH - 3;

    localparam logic [OW-1:0] OFF_TXDATA = OW'(0);
    localparam logic [OW-1:0] OFF_STATUS = OW'(1);
    localparam logic [OW-1:0] OFF_CYCLE  = OW'(2);

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic [7:0]            fifo_r [FIFO_DEPTH];
    logic [PW-1:0]         rptr_r;
    logic [PW-1:0]         wptr_r;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;
    logic [DATA_WIDTH-1:0] cycle_r;

    logic                  periph_s;
    logic [OW-1:0]         off_s;
    logic [AW-1:0]         idx_s;
    logic                  sel_tx_s;
    logic                  sel_status_s;
    logic                  sel_cycle_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  push_req_s;
    logic                  push_ok_s;
    logic                  ovf_set_s;
    logic [DATA_WIDTH-1:0] status_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    // Address decode and FIFO push/pop arbitration; a full FIFO still accepts a push when it pops.
    always_comb begin
        periph_s     = bus.i_data_addr_M[DATA_WIDTH-1];
        off_s        = bus.i_data_addr_M[DATA_WIDTH-2:2];
        idx_s        = bus.i_data_addr_M[AW+1:2];
        sel_tx_s     = periph_s && (off_s == OFF_TXDATA);
        sel_status_s = periph_s && (off_s == OFF_STATUS);
        sel_cycle_s  = periph_s && (off_s == OFF_CYCLE);
        full_s       = (count_r == CW'(FIFO_DEPTH));
        empty_s      = (count_r == CW'(0));
        pop_s        = !empty_s && bus.i_tx_ready;
        push_req_s   = bus.i_mem_write_M && sel_tx_s;
        push_ok_s    = push_req_s && (!full_s || pop_s);
        ovf_set_s    = push_req_s && full_s && !pop_s;
    end

    // STATUS word layout and load-data mux.
    always_comb begin
        status_s      = {DATA_WIDTH{1'b0}};
        status_s[5]   = overflow_r;
        status_s[4]   = full_s;
        status_s[3]   = empty_s;
        status_s[2:0] = 3'(count_r);
        rdata_s       = {DATA_WIDTH{1'b0}};
        if (!periph_s) begin
            rdata_s = mem_r[idx_s];
        end else begin
            case (off_s)
                OFF_TXDATA: rdata_s = {DATA_WIDTH{1'b0}};
                OFF_STATUS: rdata_s = status_s;
                OFF_CYCLE:  rdata_s = cycle_r;
                default:    rdata_s = {DATA_WIDTH{1'b0}};
            endcase
        end
    end

    // RAM word store; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (bus.i_mem_write_M && !periph_s) begin
            mem_r[idx_s] <= bus.i_write_data_M;
        end
    end

    // TX FIFO pointers, storage, count and sticky overflow (a new overflow beats a STATUS clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_r[i] <= 8'h00;
            end
            rptr_r     <= PW'(0);
            wptr_r     <= PW'(0);
            count_r    <= CW'(0);
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_r[wptr_r] <= bus.i_write_data_M[7:0];
                wptr_r         <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_s);
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (bus.i_mem_write_M && sel_status_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Free-running cycle counter; a CYCLE store overrides the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_r <= {DATA_WIDTH{1'b0}};
        end else if (bus.i_mem_write_M && sel_cycle_s) begin
            cycle_r <= bus.i_write_data_M;
        end else begin
            cycle_r <= cycle_r + DATA_WIDTH'(1);
        end
    end

    assign bus.o_read_data_M = rdata_s;
    assign bus.o_tx_valid    = !empty_s;
    assign bus.o_tx_data     = fifo_r[rptr_r];
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: directed scenarios followed by random traffic, all
// checked against a queue/array reference model.
module tb_dmem_responder;
    localparam logic [31:0] A_TX  = 32'h8000_0000;
    localparam logic [31:0] A_ST  = 32'h8000_0004;
    localparam logic [31:0] A_CY  = 32'h8000_0008;
    localparam logic [31:0] A_BAD = 32'h8000_0010;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dmem_responder_if #(.DATA_WIDTH(32)) bus ();

    dmem_responder #(.DATA_WIDTH(32), .MEM_DEPTH(256), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        bit          tx_valid;
        logic [7:0]  tx_data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] m_ram[int];
    logic [7:0]  m_fifo[$];
    bit          m_ovf   = 1'b0;
    logic [31:0] m_cycle = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current model state with the given address on the bus.
    function automatic exp_t predict(input logic [31:0] addr);
        exp_t e;
        int   k;
        e.chk_rd   = 1'b1;
        e.rd       = 32'd0;
        e.tx_valid = (m_fifo.size() != 0);
        e.tx_data  = e.tx_valid ? m_fifo[0] : 8'h00;
        k          = int'(addr[9:2]);
        if (!addr[31]) begin
            if (m_ram.exists(k)) e.rd = m_ram[k];
            else e.chk_rd = 1'b0;
        end else begin
            case (addr[30:2])
                29'd1:   e.rd = {26'd0, m_ovf, (m_fifo.size() == 4), (m_fifo.size() == 0), 3'(m_fifo.size())};
                29'd2:   e.rd = m_cycle;
                default: e.rd = 32'd0;
            endcase
        end
        return e;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_apply(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit ready);
        int          old_size;
        bit          pop;
        bit          ovf_set;
        logic [28:0] off;
        old_size = m_fifo.size();
        pop      = (old_size != 0) && ready;
        ovf_set  = 1'b0;
        off      = addr[30:2];
        if (we && !addr[31]) m_ram[int'(addr[9:2])] = wdata;
        if (pop) void'(m_fifo.pop_front());
        if (we && addr[31] && off == 29'd0) begin
            if (old_size < 4 || pop) m_fifo.push_back(wdata[7:0]);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (we && addr[31] && off == 29'd1) m_ovf = 1'b0;
        if (we && addr[31] && off == 29'd2) m_cycle = wdata;
        else m_cycle = m_cycle + 32'd1;
    endtask

    task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit ready);
        @(posedge clk);
        #1;
        bus.i_mem_write_M  = we;
        bus.i_data_addr_M  = addr;
        bus.i_write_data_M = wdata;
        bus.i_tx_ready     = ready;
        exp_q.push_back(predict(addr));
        model_apply(we, addr, wdata, ready);
    endtask

    task automatic do_reset(input bit chk_now);
        bus.i_mem_write_M  = 1'b0;
        bus.i_data_addr_M  = A_ST;
        bus.i_write_data_M = 32'd0;
        bus.i_tx_ready     = 1'b0;
        rst = 1'b0;
        #1;
        if (chk_now) begin
            check("reset_tx_valid", 32'(bus.o_tx_valid), 32'd0);
            check("reset_tx_data", 32'(bus.o_tx_data), 32'd0);
        end
        m_fifo.delete();
        m_ovf   = 1'b0;
        m_cycle = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(predict(A_ST));
        model_apply(1'b0, A_ST, 32'd0, 1'b0);
    endtask

    // Monitor: every cycle with a pending expectation, compare the presented outputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk_rd) check("read_data", bus.o_read_data_M, e.rd);
            check("tx_valid", 32'(bus.o_tx_valid), 32'(e.tx_valid));
            if (e.tx_valid) check("tx_data", 32'(bus.o_tx_data), 32'(e.tx_data));
        end
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        bit          ready;

        do_reset(1'b0);

        // RAM store, same-cycle old data, alias
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'h0000_0010, 32'd0, 1'b0);
        step(1'b0, 32'h0000_0410, 32'd0, 1'b0);
        step(1'b1, 32'h0000_0013, 32'h1234_5678, 1'b0);
        step(1'b0, 32'h0000_0010, 32'd0, 1'b0);

        // Fill, overflow, clear, push-with-pop at full, drain
        for (int i = 0; i < 4; i++) step(1'b1, A_TX, 32'h41 + 32'(i), 1'b0);
        step(1'b0, A_ST, 32'd0, 1'b0);
        step(1'b1, A_TX, 32'h99, 1'b0);
        step(1'b0, A_ST, 32'd0, 1'b0);
        step(1'b1, A_ST, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, A_ST, 32'd0, 1'b0);
        step(1'b1, A_TX, 32'h45, 1'b1);
        step(1'b0, A_ST, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, A_ST, 32'd0, 1'b1);

        // Counter wrap
        step(1'b1, A_CY, 32'hFFFF_FFFE, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, A_CY, 32'd0, 1'b0);

        // Unmapped peripheral word
        step(1'b0, A_BAD, 32'd0, 1'b0);
        step(1'b1, A_BAD, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, A_ST, 32'd0, 1'b0);

        // Reset mid-operation with bytes queued
        step(1'b1, A_TX, 32'h61, 1'b0);
        step(1'b1, A_TX, 32'h62, 1'b0);
        step(1'b0, A_ST, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, A_CY, 32'd0, 1'b0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            we    = ($urandom_range(0, 1) == 1);
            ready = ($urandom_range(0, 9) < 4);
            wdata = $urandom;
            case ($urandom_range(0, 6))
                0, 1:    addr = {1'b0, 21'($urandom), 8'($urandom_range(0, 7)), 2'($urandom)};
                2, 3:    addr = A_TX | 32'($urandom_range(0, 3));
                4:       addr = A_ST;
                5: begin
                    addr = A_CY;
                    we   = ($urandom_range(0, 7) == 0);
                end
                default: addr = A_BAD | (32'($urandom_range(3, 4000)) << 2);
            endcase
            step(we, addr, wdata, ready);
        end

        step(1'b0, A_ST, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
